// File: rtl/mips_cpu_muldiv_seq.sv
// Sequential HI/LO multiply/divide unit for a MIPS-style pipeline.
// Radix-2 shift-add multiply and restoring divide, 32 iterations each,
// followed by one FIX cycle that applies signs and commits HI/LO.
module mips_cpu_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        rd_req,
  output logic [31:0] hi_reg,
  output logic [31:0] lo_reg,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero
);

  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [63:0] acc;      // mult: running product; div: {remainder, quotient/dividend}
  logic [63:0] mcand;    // shifted multiplicand magnitude
  logic [31:0] opb;      // multiplier (shifted right) or divisor magnitude
  logic        is_div;
  logic        neg_q;    // sign of product or quotient
  logic        neg_r;    // sign of remainder (follows dividend)

  logic        acc_mthi, acc_mtlo, acc_mul, acc_div, accept;
  logic        signed_op, div_by_zero;
  logic [31:0] mag_a, mag_b;
  logic [33:0] trial;
  logic [63:0] product;
  logic [31:0] quot, rem;

  // Decode, next-state and combinational outputs
  always_comb begin
    acc_mthi    = 1'b0;
    acc_mtlo    = 1'b0;
    acc_mul     = 1'b0;
    acc_div     = 1'b0;
    state_next  = state;
    if (state == IDLE && start) begin
      case (opcode)
        OP_MTHI:          acc_mthi = 1'b1;
        OP_MTLO:          acc_mtlo = 1'b1;
        OP_MULT, OP_MULTU: acc_mul = 1'b1;
        OP_DIV, OP_DIVU:  acc_div  = 1'b1;
        default: ;
      endcase
    end
    accept      = acc_mthi | acc_mtlo | acc_mul | acc_div;
    signed_op   = (opcode == OP_MULT) || (opcode == OP_DIV);
    mag_a       = (signed_op && a[31]) ? -a : a;
    mag_b       = (signed_op && b[31]) ? -b : b;
    div_by_zero = acc_div && (b == 32'd0);

    case (state)
      IDLE: begin
        if (acc_mul)                     state_next = MUL;
        else if (acc_div && !div_by_zero) state_next = DIV;
      end
      MUL, DIV: begin
        if (flush)              state_next = IDLE;
        else if (count == 5'd31) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy  = (state != IDLE);
    stall = busy & (start | rd_req);

    // Trial subtraction of the divisor from {remainder, next dividend bit}
    trial   = {1'b0, acc[63:31]} - {2'b00, opb};
    product = neg_q ? -acc : acc;
    quot    = neg_q ? -acc[31:0] : acc[31:0];
    rem     = neg_r ? -acc[63:32] : acc[63:32];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath, HI/LO, done pulse and sticky divide-by-zero flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg   <= 32'd0;
      lo_reg   <= 32'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      acc      <= 64'd0;
      mcand    <= 64'd0;
      opb      <= 32'd0;
      count    <= 5'd0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept)   div_zero <= div_by_zero;
          if (acc_mthi) hi_reg <= a;
          if (acc_mtlo) lo_reg <= a;
          if (acc_mul || (acc_div && !div_by_zero)) begin
            acc    <= acc_mul ? 64'd0 : {32'd0, mag_a};
            mcand  <= {32'd0, mag_a};
            opb    <= mag_b;
            count  <= 5'd0;
            is_div <= acc_div;
            neg_q  <= signed_op & (a[31] ^ b[31]);
            neg_r  <= signed_op & a[31];
          end
          // Divide by zero completes immediately without touching HI/LO
          if (div_by_zero) done <= 1'b1;
        end
        MUL: begin
          if (opb[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          opb   <= opb >> 1;
          count <= count + 5'd1;
        end
        DIV: begin
          if (!trial[33]) acc <= {trial[31:0], acc[30:0], 1'b1};
          else            acc <= {acc[62:0], 1'b0};
          count <= count + 5'd1;
        end
        FIX: begin
          // A coinciding flush cancels the commit
          if (!flush) begin
            if (is_div) begin
              hi_reg <= rem;
              lo_reg <= quot;
            end else begin
              hi_reg <= product[63:32];
              lo_reg <= product[31:0];
            end
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Self-checking bench for mips_cpu_muldiv_seq: a transaction-level model
// (plain 64-bit arithmetic plus a latency countdown) checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mips_cpu_muldiv_seq;

  localparam logic [5:0] MTHI = 6'h11, MTLO = 6'h13, MULT = 6'h18,
                         MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] hi_reg, lo_reg;
  logic        busy, stall, done, div_zero;

  int total = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  mips_cpu_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
    .flush(flush), .rd_req(rd_req), .hi_reg(hi_reg), .lo_reg(lo_reg),
    .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done, m_dz;
  int          m_left;        // edges until the pending result commits
  longint      m_sa, m_sb, m_q, m_r;
  logic [63:0] m_pr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0;
      m_done = 0; m_dz = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1;
          end
        end
      end else if (start) begin
        case (opcode)
          MTHI: begin m_hi = a; m_dz = 0; end
          MTLO: begin m_lo = a; m_dz = 0; end
          MULT, MULTU: begin
            if (opcode == MULT) begin
              m_sa = longint'($signed(a)); m_sb = longint'($signed(b));
            end else begin
              m_sa = longint'({32'd0, a}); m_sb = longint'({32'd0, b});
            end
            m_pr = m_sa * m_sb;
            p_hi = m_pr[63:32]; p_lo = m_pr[31:0];
            m_left = 33; m_dz = 0;
          end
          DIV, DIVU: begin
            if (b == 0) begin
              m_dz = 1; m_done = 1;
            end else begin
              if (opcode == DIV) begin
                m_sa = longint'($signed(a)); m_sb = longint'($signed(b));
              end else begin
                m_sa = longint'({32'd0, a}); m_sb = longint'({32'd0, b});
              end
              m_q = m_sa / m_sb; m_r = m_sa % m_sb;
              p_lo = m_q[31:0]; p_hi = m_r[31:0];
              m_left = 33; m_dz = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(posedge clk);
    #1;
    if (reset && cmp_en) begin
      chk("hi_reg", hi_reg, m_hi);
      chk("lo_reg", lo_reg, m_lo);
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("div_zero", div_zero, m_dz);
      chk("stall", stall, (m_left > 0) && (start || rd_req));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1; opcode = op; a = x; b = y;
    @(negedge clk);
    start = 0; opcode = 0; a = 0; b = 0;
  endtask

  // Returns the number of edges after the accepting edge until done is seen, -1 on timeout
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  bit saw_done;

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk("rst_hi", hi_reg, 0);
    chk("rst_lo", lo_reg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clk);
    reset = 1;
    cmp_en = 1;

    // multu max*max with latency
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    chk("multu_latency", n, 33);
    chk("multu_hi", hi_reg, 32'hFFFFFFFE);
    chk("multu_lo", lo_reg, 32'h00000001);

    // signed mult, then back-to-back signed div issued in the done cycle
    issue(MULT, 32'hFFFFFFFD, 32'd7);
    wait_done(n);
    chk("mult_hi", hi_reg, 32'hFFFFFFFF);
    chk("mult_lo", lo_reg, 32'hFFFFFFEB);
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    chk("div_b2b_latency", n, 33);
    chk("div_lo", lo_reg, 32'hFFFFFFFD);
    chk("div_hi", hi_reg, 32'hFFFFFFFF);

    // overflow corner
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    chk("divovf_lo", lo_reg, 32'h80000000);
    chk("divovf_hi", hi_reg, 32'h00000000);

    // mthi/mtlo then divide by zero
    issue(MTHI, 32'h11111111, 32'd0);
    chk("mthi_hi", hi_reg, 32'h11111111);
    chk("mthi_busy", busy, 0);
    issue(MTLO, 32'h22222222, 32'd0);
    chk("mtlo_lo", lo_reg, 32'h22222222);
    chk("mtlo_hi", hi_reg, 32'h11111111);
    issue(DIVU, 32'd7, 32'd0);
    chk("dz_done", done, 1);
    chk("dz_flag", div_zero, 1);
    chk("dz_busy", busy, 0);
    chk("dz_hi", hi_reg, 32'h11111111);
    chk("dz_lo", lo_reg, 32'h22222222);

    // unrecognised opcode: nothing changes, sticky flag stays
    issue(6'h3F, 32'hDEADBEEF, 32'd0);
    chk("badop_dz", div_zero, 1);
    chk("badop_hi", hi_reg, 32'h11111111);

    // start and rd_req while busy: stall, second op dropped
    issue(MULTU, 32'd3, 32'd5);
    start = 1; opcode = MULTU; a = 32'd1000; b = 32'd1000;
    #1;
    chk("stall_start", stall, 1);
    repeat (3) @(negedge clk);
    start = 0; opcode = 0; a = 0; b = 0; rd_req = 1;
    #1;
    chk("stall_rdreq", stall, 1);
    @(negedge clk);
    rd_req = 0;
    wait_done(n);
    chk("drop_hi", hi_reg, 32'd0);
    chk("drop_lo", lo_reg, 32'd15);
    chk("drop_dz", div_zero, 0);

    // flush mid-divide
    issue(DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", busy, 0);
    saw_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    chk("flush_nodone", saw_done, 0);
    chk("flush_hi", hi_reg, 32'd0);
    chk("flush_lo", lo_reg, 32'd15);
    issue(DIVU, 32'd100, 32'd7);
    wait_done(n);
    chk("divu_lo", lo_reg, 32'd14);
    chk("divu_hi", hi_reg, 32'd2);

    // flush coinciding with the commit cycle
    issue(MULTU, 32'd9, 32'd9);
    repeat (32) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fixflush_done", done, 0);
    chk("fixflush_busy", busy, 0);
    chk("fixflush_lo", lo_reg, 32'd14);
    chk("fixflush_hi", hi_reg, 32'd2);

    // flush in IDLE does not block acceptance
    @(negedge clk);
    start = 1; opcode = MTHI; a = 32'h0000ABCD; flush = 1;
    @(negedge clk);
    start = 0; opcode = 0; a = 0; flush = 0;
    chk("idleflush_hi", hi_reg, 32'h0000ABCD);

    // asynchronous reset mid-multiply
    issue(MULT, 32'hFFFFFFFD, 32'd7);
    repeat (19) @(negedge clk);
    rd_req = 1;
    #2;
    reset = 0;
    #1;
    chk("arst_hi", hi_reg, 0);
    chk("arst_lo", lo_reg, 0);
    chk("arst_busy", busy, 0);
    chk("arst_stall", stall, 0);
    chk("arst_done", done, 0);
    chk("arst_dz", div_zero, 0);
    @(negedge clk);
    reset = 1;
    rd_req = 0;
    issue(MTLO, 32'd5, 32'd0);
    chk("post_rst_lo", lo_reg, 32'd5);
    chk("post_rst_hi", hi_reg, 32'd0);
    chk("post_rst_busy", busy, 0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
